// File: rtl/dlatch_bank.sv
// Multi-channel storage bank with global FLOP/TRANSP/HOLD/CLEAR mode, per-channel
// change pulses and an atomic snapshot port with a valid/ready handshake.
module dlatch_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   mode_i,
  input  logic [CHANNELS-1:0]          en_i,
  input  logic [CHANNELS*WIDTH-1:0]    d_i,
  output logic [CHANNELS*WIDTH-1:0]    q_o,
  output logic [CHANNELS-1:0]          change_o,
  input  logic                         snap_req_i,
  output logic [CHANNELS*WIDTH-1:0]    snap_data_o,
  output logic                         snap_valid_o,
  input  logic                         snap_ready_i,
  output logic                         overrun_o
);

  localparam logic [1:0] MODE_FLOP   = 2'b00;
  localparam logic [1:0] MODE_TRANSP = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } snap_state_e;

  // Packed [channel][bit] views share the flat port layout: channel c at [c*WIDTH +: WIDTH].
  logic [CHANNELS-1:0][WIDTH-1:0] d_w;
  logic [CHANNELS-1:0][WIDTH-1:0] q_w;
  logic [CHANNELS-1:0][WIDTH-1:0] store_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] store_p0;
  logic [CHANNELS-1:0]            change_p1;
  logic [CHANNELS-1:0][WIDTH-1:0] snap_data_p1;
  logic                           overrun_p1;
  logic                           snap_capture;
  logic                           overrun_set;
  snap_state_e                    snap_state;
  snap_state_e                    snap_state_nxt;

  assign d_w = d_i;

  always_comb begin
    store_nxt = store_p0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_i)
        MODE_FLOP, MODE_TRANSP: begin
          if (en_i[c]) store_nxt[c] = d_w[c];
        end
        MODE_CLEAR: store_nxt[c] = RESET_VAL;
        default:    store_nxt[c] = store_p0[c];
      endcase
    end
  end

  // Stage p0: per-channel storage; p1: change detect against the pre-edge value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_p0  <= {CHANNELS{RESET_VAL}};
      change_p1 <= '0;
    end else begin
      store_p0 <= store_nxt;
      for (int c = 0; c < CHANNELS; c++) begin
        change_p1[c] <= (store_nxt[c] != store_p0[c]);
      end
    end
  end

  // Transparent mode emulates a latch with a mux bypass instead of a real latch.
  always_comb begin
    q_w = store_p0;
    if (mode_i == MODE_TRANSP) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (en_i[c]) q_w[c] = d_w[c];
      end
    end
  end

  always_comb begin
    snap_state_nxt = snap_state;
    snap_capture   = 1'b0;
    overrun_set    = 1'b0;
    case (snap_state)
      S_IDLE: begin
        if (snap_req_i) begin
          snap_capture   = 1'b1;
          snap_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (snap_req_i && snap_ready_i) begin
          snap_capture = 1'b1;
        end else if (snap_ready_i) begin
          snap_state_nxt = S_IDLE;
        end else if (snap_req_i) begin
          overrun_set = 1'b1;
        end
      end
      default: snap_state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: snapshot register captures the stored values seen before this edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_state   <= S_IDLE;
      snap_data_p1 <= '0;
      overrun_p1   <= 1'b0;
    end else begin
      snap_state <= snap_state_nxt;
      if (snap_capture) snap_data_p1 <= store_p0;
      if (overrun_set)  overrun_p1   <= 1'b1;
    end
  end

  assign q_o          = q_w;
  assign change_o     = change_p1;
  assign snap_data_o  = snap_data_p1;
  assign snap_valid_o = (snap_state == S_VALID);
  assign overrun_o    = overrun_p1;

endmodule

// File: doc/dlatch_bank.md
Name: dlatch_bank

Overview:
- Parametrised, multi-channel successor to the single-bit transparent D storage element.
- Holds CHANNELS independent WIDTH-bit values.
- A global mode selects edge-capture, emulated transparent-latch, hold or clear behaviour, all fully synchronous to one clock.
- Adds per-channel change pulses and an atomic all-channel snapshot port with a valid/ready handshake, for debug and readback logic downstream.

Parameters:
- WIDTH, 8, bits per channel (>=1).
- CHANNELS, 4, number of channels (>=1).
- RESET_VAL, 0, WIDTH-bit value loaded into every channel on reset and in CLEAR mode.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  asynchronous, active-high reset.
- mode_i  input  2  global mode: 00 FLOP, 01 TRANSP, 10 HOLD, 11 CLEAR.
- en_i  input  CHANNELS  per-channel enable; bit c governs channel c.
- d_i  input  CHANNELS*WIDTH  channel c data at bits [c*WIDTH +: WIDTH].
- q_o  output  CHANNELS*WIDTH  channel outputs, same packing as d_i.
- change_o  output  CHANNELS  one-cycle pulse: channel's stored value changed at the previous edge.
- snap_req_i  input  1  request to snapshot all stored values.
- snap_data_o  output  CHANNELS*WIDTH  captured snapshot.
- snap_valid_o  output  1  snapshot available.
- snap_ready_i  input  1  consumer accepts snapshot.
- overrun_o  output  1  sticky: a request was dropped.

Behaviour:
- Reset (async assert, takes effect immediately):
  - All stored regs = RESET_VAL; q_o = RESET_VAL in every channel.
  - change_o = 0, snap_data_o = 0, snap_valid_o = 0, overrun_o = 0, FSM = IDLE.
  - Reset mid-snapshot discards the snapshot.
- Storage update per channel c at each rising edge:
  - FLOP: stored[c] <= d[c] if en_i[c], else holds.
  - TRANSP: same register update as FLOP.
  - HOLD: no update regardless of en_i.
  - CLEAR: stored[c] <= RESET_VAL for all channels, en_i ignored.
- q_o:
  - TRANSP: q[c] = en_i[c] ? d[c] : stored[c], a combinational bypass with zero latency. When en falls, q holds the value captured at the last edge with en high; d changes between edges while en is high appear on q but are not retained.
  - All other modes: q[c] = stored[c], registered, one-cycle latency from d.
  - No real latches are inferred.
- Mode changes take effect at the same edge they are sampled.
- change_o[c]: registered. It is 1 for exactly one cycle after an edge at which stored[c] took a value different from its previous value. Rewriting an equal value gives no pulse; CLEAR of an already-RESET_VAL channel gives no pulse.
- Snapshot FSM, two states, IDLE and VALID:
  - IDLE: snap_req_i=1 at an edge causes snap_data_o <= stored values before that edge's update, snap_valid_o <= 1, and a move to VALID.
  - VALID: snap_data_o is stable. snap_ready_i=1 with snap_req_i=0 causes a move to IDLE with valid=0.
  - VALID with snap_ready_i=1 and snap_req_i=1 (back-to-back): recapture the new pre-edge values and stay in VALID with valid=1.
  - VALID with snap_req_i=1 and snap_ready_i=0: request dropped, overrun_o <= 1. overrun_o is cleared only by reset.
  - snap_ready_i in IDLE is ignored.
- Snapshot operation is independent of mode_i, so snapshots are allowed in HOLD and CLEAR.

Test Plan:
- Reset: assert rst_i mid-cycle with RESET_VAL=8'hA5. q_o = 32'hA5A5A5A5 immediately, with valid, change_o and overrun_o = 0. Release, then keep mode HOLD for 3 cycles: q unchanged.
- FLOP: en_i=4'b0101, d_i=32'h44332211, one edge. Expect q_o=32'hA533A511 after the edge, change_o=4'b0101 for one cycle. Repeat the same d: change_o stays 0.
- TRANSP: mode=01, en_i[0]=1, drive d0=8'h10 then 8'h20 within one cycle. q0 follows combinationally. Drop en before the next edge: q0 shows the value sampled at the last edge with en high.
- CLEAR/HOLD: from q=32'h44332211, apply CLEAR for one edge. Expect q=32'hA5A5A5A5 and change_o=4'b1111. Switch to HOLD with en_i=4'hF and new data: q unchanged.
- Snapshot: pulse snap_req_i with stored=32'h01020304. Next cycle valid=1 and data=32'h01020304. Change the stored values: data stays stable. Raise snap_ready_i: valid drops next cycle.
- Back-to-back and overrun: hold snap_req_i and snap_ready_i high for 3 cycles; valid stays 1 and data tracks each cycle's pre-edge stored values. Then req=1 with ready=0 while VALID: overrun_o=1, persisting until rst_i.
